button_scanner: RTL and testbench

- Debounce controller for the console's button inputs.
- One debounce engine is shared round-robin across NUM_BUTTONS raw inputs. Per-button counters are held in a register array and serviced one button per clock.
- Maintains the debounced state vector and sticky press-event latches.
- Exposes a one-word read-to-clear port to the CPU I/O bus, plus a level interrupt.

---
 rtl/button_scanner_if.sv | 21 ++
 rtl/button_scanner.sv | 91 +++++++++
 tb/tb_button_scanner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_scanner_if.sv
// CPU-side read-to-clear port and interrupt of the button scanner.
interface button_scanner_if;
    logic        rd_req;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        irq;

    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_data,
        output irq
    );
endinterface

// File: rtl/button_scanner.sv
// Round-robin shared debounce engine with sticky press events and read-to-clear.
// Define BUTTON_RELEASE_EVENTS_EN to add release latches in rd_data[15:8].
module button_scanner #(
    parameter int NUM_BUTTONS   = 8,
    parameter int COUNTER_SIZE  = 8,
    parameter int COUNTER_VALUE = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    output logic [NUM_BUTTONS-1:0] buttons_state,
    button_scanner_if.slave        bus
);
    localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BUTTONS - 1);
    localparam logic [COUNTER_SIZE-1:0] CNT_LAST = COUNTER_SIZE'(COUNTER_VALUE - 1);

    logic [NUM_BUTTONS-1:0]  sync_q1;
    logic [NUM_BUTTONS-1:0]  sync_q2;
    logic [IDX_W-1:0]        idx;
    logic [COUNTER_SIZE-1:0] count [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0]  press_ev;
    logic [NUM_BUTTONS-1:0]  press_set;
    logic [NUM_BUTTONS-1:0]  press_nxt;
    logic                    disagree;
    logic                    flip;
    logic [15:0]             snapshot;
    logic                    any_ev;
`ifdef BUTTON_RELEASE_EVENTS_EN
    logic [NUM_BUTTONS-1:0]  release_ev;
    logic [NUM_BUTTONS-1:0]  release_set;
    logic [NUM_BUTTONS-1:0]  release_nxt;
`endif

    always_comb begin
        disagree  = sync_q2[idx] != buttons_state[idx];
        flip      = disagree && (count[idx] == CNT_LAST);
        press_set = '0;
        if (flip && sync_q2[idx])
            press_set[idx] = 1'b1;
        // A read clears the whole snapshot; an event landing on the same edge survives.
        press_nxt = (bus.rd_req ? '0 : press_ev) | press_set;
        snapshot  = '0;
        snapshot[NUM_BUTTONS-1:0] = press_ev;
`ifdef BUTTON_RELEASE_EVENTS_EN
        release_set = '0;
        if (flip && !sync_q2[idx])
            release_set[idx] = 1'b1;
        release_nxt = (bus.rd_req ? '0 : release_ev) | release_set;
        snapshot[8 +: NUM_BUTTONS] = release_ev;
        any_ev = |{press_nxt, release_nxt};
`else
        any_ev = |press_nxt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q1       <= '0;
            sync_q2       <= '0;
            idx           <= '0;
            buttons_state <= '0;
            press_ev      <= '0;
            bus.rd_ack    <= 1'b0;
            bus.rd_data   <= '0;
            bus.irq       <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++)
                count[i] <= '0;
`ifdef BUTTON_RELEASE_EVENTS_EN
            release_ev    <= '0;
`endif
        end else begin
            sync_q1 <= buttons_in;
            sync_q2 <= sync_q1;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (!disagree || flip)
                count[idx] <= '0;
            else
                count[idx] <= count[idx] + 1'b1;
            if (flip)
                buttons_state[idx] <= sync_q2[idx];
            press_ev    <= press_nxt;
            bus.rd_ack  <= bus.rd_req;
            bus.rd_data <= bus.rd_req ? snapshot : '0;
            bus.irq     <= any_ev;
`ifdef BUTTON_RELEASE_EVENTS_EN
            release_ev  <= release_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_button_scanner.sv
// Directed plus random checks of button_scanner against a cycle-level reference model.
module tb_button_scanner;
    localparam int NB = 4;
    localparam int CV = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] buttons_in;
    logic [NB-1:0] buttons_state;

    button_scanner_if bus ();

    button_scanner #(
        .NUM_BUTTONS   (NB),
        .COUNTER_SIZE  (2),
        .COUNTER_VALUE (CV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .buttons_in    (buttons_in),
        .buttons_state (buttons_state),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: raw input history, run length of disagreeing visits
    bit [NB-1:0] h1, h2;
    int          m_run [NB];
    bit [NB-1:0] m_state, m_press, m_rel;
    int          m_pos;
    bit          m_ack, m_irq;
    bit [15:0]   m_data;

    task automatic model_step(input bit [NB-1:0] b, input bit r, input bit rst);
        bit [NB-1:0] s;
        bit [NB-1:0] rise;
        bit [NB-1:0] fall;
        int i;
        if (!rst) begin
            h1 = '0; h2 = '0; m_state = '0; m_press = '0; m_rel = '0;
            m_pos = 0; m_ack = 0; m_irq = 0; m_data = '0;
            for (int k = 0; k < NB; k++) m_run[k] = 0;
        end else begin
            s = h2; rise = '0; fall = '0; i = m_pos;
            if (s[i] == m_state[i]) m_run[i] = 0;
            else if (m_run[i] + 1 == CV) begin
                m_run[i] = 0;
                m_state[i] = s[i];
                if (s[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
            end else m_run[i] = m_run[i] + 1;
            m_ack = r;
            m_data = '0;
            if (r) begin
                m_data[NB-1:0] = m_press;
`ifdef BUTTON_RELEASE_EVENTS_EN
                m_data[8 +: NB] = m_rel;
`endif
                m_press = '0;
                m_rel = '0;
            end
            m_press |= rise;
`ifdef BUTTON_RELEASE_EVENTS_EN
            m_rel |= fall;
`endif
            m_irq = |{m_press, m_rel};
            h2 = h1; h1 = b;
            m_pos = (m_pos + 1) % NB;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step(buttons_in, bus.rd_req, reset);
        @(posedge clk);
        #1;
        chk("state", 16'(buttons_state), 16'(m_state));
        chk("rd_ack", 16'(bus.rd_ack), 16'(m_ack));
        chk("rd_data", bus.rd_data, m_data);
        chk("irq", 16'(bus.irq), 16'(m_irq));
    endtask

    task automatic rd_and_chk(input string tag, input logic [15:0] exp);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        chk({tag, "_ack"}, 16'(bus.rd_ack), 16'h0001);
        chk({tag, "_data"}, bus.rd_data, exp);
    endtask

    initial begin
        bit hit;
        int lat;
        reset = 1'b0;
        buttons_in = '0;
        bus.rd_req = 1'b0;
        tick();
        tick();
        chk("rst_state", 16'(buttons_state), 16'h0000);
        chk("rst_ack", 16'(bus.rd_ack), 16'h0000);
        chk("rst_data", bus.rd_data, 16'h0000);
        chk("rst_irq", 16'(bus.irq), 16'h0000);

        // 1: single press, latency bound, read clears irq
        reset = 1'b1;
        buttons_in = 4'b0001;
        hit = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (buttons_state[0]) begin hit = 1; break; end
        end
        chk("s1_rise_in_bound", 16'(hit), 16'h0001);
        chk("s1_irq_same_cycle", 16'(bus.irq), 16'h0001);
        rd_and_chk("s1_rd", 16'h0001);
        tick();
        chk("s1_irq_cleared", 16'(bus.irq), 16'h0000);

        // 2: glitch on button 2 is rejected, steady press is accepted
        buttons_in[2] = 1'b1;
        repeat (5) tick();
        buttons_in[2] = 1'b0;
        repeat (6) tick();
        chk("s2_glitch_state", 16'(buttons_state[2]), 16'h0000);
        chk("s2_glitch_irq", 16'(bus.irq), 16'h0000);
        buttons_in[2] = 1'b1;
        repeat (16) tick();
        chk("s2_steady_state", 16'(buttons_state[2]), 16'h0001);
        rd_and_chk("s2_rd", 16'h0004);

        // 3: event on the same edge as the read survives it
        buttons_in[1] = 1'b1;
        hit = 0;
        for (int k = 0; k < 24; k++) begin
            if (m_pos == 1 && h2[1] && !m_state[1] && m_run[1] == CV - 1) begin
                hit = 1;
                rd_and_chk("s3_rd_race", 16'h0000);
                break;
            end
            tick();
        end
        chk("s3_race_found", 16'(hit), 16'h0001);
        chk("s3_irq_kept", 16'(bus.irq), 16'h0001);
        rd_and_chk("s3_rd_second", 16'h0002);
        tick();
        chk("s3_irq_dropped", 16'(bus.irq), 16'h0000);

        // 4: two buttons pressed together
        buttons_in = 4'b0000;
        repeat (20) tick();
        rd_and_chk("s4_rd_clear", m_data);
        tick();
        buttons_in = 4'b1010;
        repeat (20) tick();
        chk("s4_state", 16'(buttons_state), 16'h000A);
        rd_and_chk("s4_rd", 16'h000A);

        // 5: reset mid-count discards it; read during reset is ignored
        buttons_in = 4'b1011;
        hit = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_run[0] == CV - 1) begin hit = 1; break; end
        end
        chk("s5_count_reached", 16'(hit), 16'h0001);
        reset = 1'b0;
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        chk("s5_rst_state", 16'(buttons_state), 16'h0000);
        chk("s5_rst_irq", 16'(bus.irq), 16'h0000);
        tick();
        chk("s5_rst_no_ack", 16'(bus.rd_ack), 16'h0000);
        reset = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (buttons_state[0]) begin lat = k; break; end
        end
        chk("s5_relatency", 16'(lat), 16'd13);
        repeat (12) tick();
        rd_and_chk("s5_rd", 16'h000B);

        // 6: press then release of button 0
        buttons_in = 4'b0000;
        repeat (20) tick();
        rd_and_chk("s6_rd_clear", m_data);
        buttons_in = 4'b0001;
        repeat (20) tick();
        buttons_in = 4'b0000;
        repeat (20) tick();
`ifdef BUTTON_RELEASE_EVENTS_EN
        rd_and_chk("s6_rd", 16'h0101);
`else
        rd_and_chk("s6_rd", 16'h0001);
`endif

        // Random soak against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(11) == 0)
                buttons_in[$urandom_range(NB - 1)] ^= 1'b1;
            bus.rd_req = ($urandom_range(4) == 0);
            reset = ($urandom_range(299) != 0);
            tick();
        end
        reset = 1'b1;
        bus.rd_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
